// File: rtl/uart_rx_cmd_ctrl.sv
// Turns UART byte strobes into SYNC/ADDR/LEN/payload/CSUM frames and writes a verified payload to the register file.
// Latency: the write burst starts one cycle after the CSUM byte; wr_ready stalls hold the write, and bytes arriving during the burst are dropped.
module uart_rx_cmd_ctrl #(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CLKS = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_done,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM, S_WRITE, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    base_q, base_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    csum_q, csum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;
    logic          mem_we;
    logic          in_frame;
    logic [AW-1:0] mem_idx;
    logic [7:0]    pay_mem [MAX_LEN];

    assign mem_idx  = idx_q[AW-1:0];
    assign in_frame = (state_q == S_ADDR) || (state_q == S_LEN) ||
                      (state_q == S_DATA) || (state_q == S_CSUM);

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        tmo_d   = '0;
        err_d   = 1'b0;
        code_d  = code_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) state_d = S_ADDR;
            end
            S_ADDR: begin
                if (rx_valid) begin
                    base_d  = rx_data;
                    csum_d  = rx_data;
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (rx_valid) begin
                    if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                        err_d   = 1'b1;
                        code_d  = 2'b01;
                        state_d = S_IDLE;
                    end else begin
                        len_d   = rx_data;
                        csum_d  = csum_q ^ rx_data;
                        idx_d   = 8'd0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    mem_we = 1'b1;
                    csum_d = csum_q ^ rx_data;
                    idx_d  = idx_q + 8'd1;
                    if (idx_q == len_q - 8'd1) state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == csum_q) begin
                        idx_d   = 8'd0;
                        state_d = S_WRITE;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = 2'b10;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                if (wr_ready) begin
                    idx_d = idx_q + 8'd1;
                    if (idx_q == len_q - 8'd1) begin
                        code_d  = 2'b00;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A byte landing on the terminal count wins over the timeout.
        if (in_frame && !rx_valid) begin
            if (tmo_q == TMO_LAST) begin
                err_d   = 1'b1;
                code_d  = 2'b11;
                state_d = S_IDLE;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            base_q  <= 8'd0;
            len_q   <= 8'd0;
            idx_q   <= 8'd0;
            csum_q  <= 8'd0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) pay_mem[mem_idx] <= rx_data;
    end

    assign wr_valid   = (state_q == S_WRITE);
    assign wr_addr    = wr_valid ? base_q + idx_q : 8'd0;
    assign wr_data    = wr_valid ? pay_mem[mem_idx] : 8'd0;
    assign frame_done = (state_q == S_DONE);
    assign frame_err  = err_q;
    assign err_code   = code_q;
    assign busy       = (state_q != S_IDLE);
endmodule

// File: doc/uart_rx_cmd_ctrl.md
Name: uart_rx_cmd_ctrl

Overview:
- Frame-level controller sitting directly behind the UART byte receiver. It consumes its one-cycle byte strobes and sequences them into command frames.
- Frame format: SYNC, ADDR, LEN, LEN payload bytes, CSUM.
- Payload is buffered internally and released as a write burst to a downstream register file only after the checksum is verified.
- Malformed, corrupt or stalled frames are reported with an error pulse and code.

Parameters:
- MAX_LEN, 16, maximum payload bytes per frame (legal 1..255); sets buffer depth.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CLKS, 2604, max clocks between consecutive bytes inside a frame (12 bit-times at 217 clks/bit).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_valid  in  1  one-cycle strobe from UART receiver, byte available
- rx_data  in  8  received byte, valid when rx_valid=1
- wr_valid  out  1  write request to register file
- wr_ready  in  1  register file accepts write this cycle
- wr_addr  out  8  write address
- wr_data  out  8  write data
- frame_done  out  1  one-cycle pulse, frame fully written
- frame_err  out  1  one-cycle pulse, frame aborted
- err_code  out  2  last error: 00 none, 01 bad LEN, 10 checksum, 11 timeout
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state=IDLE; wr_valid, frame_done, frame_err, busy, err_code all 0; wr_addr/wr_data 0; index and timeout counters 0. Buffer contents are not cleared (don't care).
- Reset mid-frame or mid-burst abandons the frame with no done/err pulse.
- States: IDLE, ADDR, LEN, DATA, CSUM, WRITE, DONE.
- IDLE:
  - rx_valid with rx_data==SYNC_BYTE -> ADDR.
  - Any other byte is ignored silently.
- ADDR: next byte -> base address; running xor := byte -> LEN.
- LEN:
  - Byte==0 or >MAX_LEN -> error 01, IDLE.
  - Else store len, xor ^= byte, idx:=0 -> DATA.
- DATA:
  - Each byte stored to buf[idx]; xor ^= byte; idx++.
  - After the len-th byte -> CSUM.
- CSUM:
  - Byte==xor -> WRITE, idx:=0.
  - Mismatch -> error 10, IDLE.
  - Nothing is written on any error.
- Timeout (ADDR/LEN/DATA/CSUM only):
  - Counter clears on every rx_valid and on state entry, increments otherwise.
  - Reaching TIMEOUT_CLKS-1 without a byte -> error 11, IDLE.
  - rx_valid in the terminal-count cycle: the byte is accepted, no timeout.
- WRITE:
  - wr_valid=1, wr_addr=base+idx (8-bit wrap, 8'hFF+1=8'h00), wr_data=buf[idx].
  - wr_addr/wr_data are held stable while wr_valid && !wr_ready.
  - Transfer on wr_valid&&wr_ready; idx++.
  - After the len-th transfer, wr_valid drops next cycle -> DONE.
  - rx_valid during WRITE/DONE is dropped, including SYNC bytes.
- DONE: frame_done=1 for one cycle, err_code:=00 -> IDLE.
- Error entry: frame_err=1 for the single cycle following the offending byte or timeout. err_code is updated in that same cycle and held until the next frame_done or frame_err.
- Latency:
  - CSUM byte strobe at cycle N -> wr_valid=1 at N+1.
  - With wr_ready tied high: last write at N+len, frame_done at N+len+1, busy low at N+len+2.
- Back-to-back frames: a SYNC byte accepted on the first IDLE cycle is legal.

Test Plan:
- A5,10,02,11,22,CSUM=10^02^11^22=21, wr_ready=1 -> writes (10,11),(11,22) on consecutive cycles; frame_done 1 cycle later; err_code=00.
- Same frame with CSUM=20 -> no wr_valid; frame_err pulse; err_code=10; busy=0 next cycle.
- LEN=00, then a second frame with LEN=MAX_LEN+1 -> each gives frame_err with err_code=01; the MAX_LEN frame with ADDR=F8 writes F8..FF then wraps to 00..07.
- A5,10, then no byte for TIMEOUT_CLKS -> frame_err, err_code=11; a byte arriving exactly at terminal count is accepted instead.
- wr_ready toggled 1,0,0,1 during the burst -> addr/data held while stalled; exactly len transfers; bytes injected during WRITE are ignored.
- rst asserted mid-DATA and mid-WRITE -> all outputs 0 next cycle; no done/err pulse; a following clean frame succeeds.
